l2_tile_arb: RTL

L2_TILE_ARB -- requirements
Module: l2_tile_arb

---
 rtl/l2_tile_arb.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/l2_tile_arb.sv
// l2_tile_arb: round-robin arbiter funnelling TILES L1 request streams into one
// registered L2 request port, with credit limiting on in-flight requests and a
// combinational fan-out of L2 responses back to the owning tile.

// Response steering slice for one tile: claims the response when its tag matches.
module l2_tile_arb_rsp_lane #(
  parameter int LANE       = 0,
  parameter int clid_width = 4,
  parameter int tid_width  = 2
) (
  input  logic                  en,
  input  logic                  rsp_v,
  input  logic [tid_width-1:0]  rsp_tid,
  input  logic [clid_width-1:0] rsp_clid,
  output logic                  hit,
  output logic                  lane_v,
  output logic [clid_width-1:0] lane_clid
);

  assign hit       = (int'(rsp_tid) == LANE);
  assign lane_v    = en & rsp_v & hit;
  assign lane_clid = rsp_clid;

endmodule

module l2_tile_arb #(
  parameter int TILES      = 4,
  parameter int clid_width = 4,
  parameter int tid_width  = $clog2(TILES),
  parameter int max_outst  = 8,
  parameter int cnt_width  = $clog2(max_outst + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  // tile request side
  input  logic [TILES-1:0]              i_req_v,
  output logic [TILES-1:0]              i_req_r,
  input  logic [TILES*clid_width-1:0]   i_req_clid,
  // L2 request side
  output logic                          o_l2_req_v,
  input  logic                          o_l2_req_r,
  output logic [clid_width-1:0]         o_l2_req_clid,
  output logic [tid_width-1:0]          o_l2_req_tid,
  // L2 response side
  input  logic                          i_l2_rsp_v,
  output logic                          i_l2_rsp_r,
  input  logic [clid_width-1:0]         i_l2_rsp_clid,
  input  logic [tid_width-1:0]          i_l2_rsp_tid,
  // tile response side
  output logic [TILES-1:0]              o_rsp_v,
  input  logic [TILES-1:0]              o_rsp_r,
  output logic [TILES*clid_width-1:0]   o_rsp_clid,
  // status
  output logic [cnt_width-1:0]          o_outst,
  output logic                          o_err
);

  localparam logic [cnt_width-1:0] MAX_CNT = cnt_width'(max_outst);

  // First requester at or after 'start' in circular order; MSB flags a hit.
  // Walking the order backwards lets the earliest candidate overwrite the rest.
  function automatic logic [tid_width:0] rr_pick(input logic [TILES-1:0] v,
                                                 input logic [tid_width-1:0] start);
    logic [tid_width:0] r;
    int t;
    r = '0;
    for (int k = TILES - 1; k >= 0; k--) begin
      t = int'(start) + k;
      if (t >= TILES) t = t - TILES;
      if (v[t]) r = {1'b1, tid_width'(t)};
    end
    return r;
  endfunction

  // Pointer step with wrap at TILES (TILES need not be a power of two).
  function automatic logic [tid_width-1:0] rr_inc(input logic [tid_width-1:0] i);
    int n;
    n = int'(i) + 1;
    if (n >= TILES) n = 0;
    return tid_width'(n);
  endfunction

  logic [TILES-1:0][clid_width-1:0] req_clid_arr;
  logic [TILES-1:0][clid_width-1:0] rsp_clid_arr;
  logic [tid_width-1:0]             rr;
  logic [tid_width-1:0]             rr_nxt;
  logic [tid_width-1:0]             gnt_idx;
  logic [tid_width:0]               pick;
  logic                             slot_free;
  logic                             credit_ok;
  logic                             grant;
  logic [TILES-1:0]                 gnt_oh;
  logic [clid_width-1:0]            gnt_clid;
  logic [TILES-1:0]                 lane_hit;
  logic                             tid_ok;
  logic                             rsp_hs;
  logic                             bad_rsp;
  logic [cnt_width-1:0]             cnt;

  assign req_clid_arr = i_req_clid;

  // Output slot can take a new request if empty or draining this cycle;
  // credit is judged on the registered count only, so a same-cycle response
  // does not open an extra slot.
  assign slot_free = ~o_l2_req_v | o_l2_req_r;
  assign credit_ok = cnt < MAX_CNT;
  assign pick      = rr_pick(i_req_v, rr);
  assign gnt_idx   = pick[tid_width-1:0];
  assign grant     = ~reset & slot_free & credit_ok & pick[tid_width];
  assign rr_nxt    = rr_inc(gnt_idx);

  // One-hot ready to the winner and mux of its cacheline id.
  always_comb begin
    gnt_oh   = '0;
    gnt_clid = '0;
    for (int t = 0; t < TILES; t++) begin
      gnt_oh[t] = grant & (int'(gnt_idx) == t);
      if (gnt_oh[t]) gnt_clid = req_clid_arr[t];
    end
  end

  assign i_req_r = gnt_oh;

  // Per-tile response steering.
  for (genvar g = 0; g < TILES; g++) begin : g_lane
    l2_tile_arb_rsp_lane #(
      .LANE       (g),
      .clid_width (clid_width),
      .tid_width  (tid_width)
    ) u_lane (
      .en        (~reset),
      .rsp_v     (i_l2_rsp_v),
      .rsp_tid   (i_l2_rsp_tid),
      .rsp_clid  (i_l2_rsp_clid),
      .hit       (lane_hit[g]),
      .lane_v    (o_rsp_v[g]),
      .lane_clid (rsp_clid_arr[g])
    );
  end

  assign o_rsp_clid = rsp_clid_arr;

  // A tag that matches no tile is swallowed so the L2 side never stalls on it.
  assign tid_ok     = |lane_hit;
  assign i_l2_rsp_r = ~reset & (tid_ok ? |(lane_hit & o_rsp_r) : 1'b1);
  assign rsp_hs     = i_l2_rsp_v & i_l2_rsp_r;
  assign bad_rsp    = rsp_hs & (~tid_ok | (cnt == '0));

  // Output stage: load on grant, drop valid once the L2 side has taken it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_l2_req_v    <= 1'b0;
      o_l2_req_clid <= '0;
      o_l2_req_tid  <= '0;
    end else if (grant) begin
      o_l2_req_v    <= 1'b1;
      o_l2_req_clid <= gnt_clid;
      o_l2_req_tid  <= gnt_idx;
    end else if (o_l2_req_r) begin
      o_l2_req_v    <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the last winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rr <= '0;
    else if (grant) rr <= rr_nxt;
  end

  // In-flight count: +1 per grant, -1 per response, clamped at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   cnt <= '0;
    else if (grant & ~rsp_hs)                    cnt <= cnt + 1'b1;
    else if (rsp_hs & ~grant & (cnt != '0))      cnt <= cnt - 1'b1;
  end

  // Sticky error on stray responses (unknown tile or nothing outstanding).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        o_err <= 1'b0;
    else if (bad_rsp) o_err <= 1'b1;
  end

  assign o_outst = cnt;

endmodule
